// File: rtl/VX_imem_pkg.sv
// Shared definitions for the instruction-memory responder slice.
package VX_imem_pkg;

  localparam int IMEM_WORD_WIDTH = 32;
  localparam int IMEM_ADDR_WIDTH = 30;
  localparam int IMEM_TAG_WIDTH  = 8;

  localparam logic [IMEM_WORD_WIDTH-1:0] IMEM_NOP = 32'h00000013;

  // Response record; users with a different tag width declare a matching
  // struct and hand it to the buffer through its type parameter.
  typedef struct packed {
    logic [IMEM_WORD_WIDTH-1:0] data;
    logic [IMEM_TAG_WIDTH-1:0]  tag;
  } imem_rsp_t;

endpackage

// File: rtl/VX_icache_rsp_buf.sv
// First-word-fall-through response buffer with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module VX_icache_rsp_buf
  import VX_imem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = imem_rsp_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  T            entries [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = entries[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally through the extra bit
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage, no reset needed since reads are qualified by empty
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vx_icache_responder.sv
// Instruction-memory responder standing in for the I-cache.
// Fixed-latency read pipeline feeding a credit-limited FWFT response buffer.
// Optional macro VX_ICACHE_RESPONDER_BOUNDS_EN: out-of-range fetches return
// a NOP and raise a sticky err flag; otherwise addresses wrap.
module vx_icache_responder
  import VX_imem_pkg::*;
#(
  parameter int CORE_ID        = 0,
  parameter int TAG_WIDTH      = 8,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int LATENCY        = 2,
  parameter int RSP_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       icache_req_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] icache_req_addr,
  input  logic [TAG_WIDTH-1:0]       icache_req_tag,
  output logic                       icache_req_ready,
  output logic                       icache_rsp_valid,
  output logic [IMEM_WORD_WIDTH-1:0] icache_rsp_data,
  output logic [TAG_WIDTH-1:0]       icache_rsp_tag,
  input  logic                       icache_rsp_ready,
  input  logic                       prog_wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0]  prog_wr_addr,
  input  logic [IMEM_WORD_WIDTH-1:0] prog_wr_data,
  output logic                       busy,
  output logic                       err,
  output logic [IMEM_ADDR_WIDTH-1:0] err_addr
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int CW        = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic [IMEM_WORD_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]       tag;
  } rsp_t;

  logic [CW-1:0]              cnt;
  logic                       req_fire;
  logic                       rsp_fire;
  logic [IMEM_WORD_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IMEM_WORD_WIDTH-1:0] rd_q;
  logic [IMEM_WORD_WIDTH-1:0] st0_data;
  logic [IMEM_WORD_WIDTH-1:0] tail_data;
  logic [LATENCY-1:0]         pv;
  logic [TAG_WIDTH-1:0]       pt [LATENCY];
  logic                       tail_valid;
  rsp_t                       tail_rsp;
  rsp_t                       buf_head;
  logic                       buf_push;
  logic                       buf_pop;
  logic                       buf_empty;
  logic                       buf_full;

  assign icache_req_ready = (cnt < CW'(RSP_DEPTH));
  assign req_fire         = icache_req_valid && icache_req_ready;
  assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;
  assign busy             = (cnt != '0);

  // Outstanding credit counter: in-flight plus buffered responses
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (req_fire && !rsp_fire) begin
      cnt <= cnt + CW'(1);
    end else if (!req_fire && rsp_fire) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Instruction memory: program write port plus read-old-data fetch port
  always_ff @(posedge clk) begin
    if (prog_wr_en) mem[prog_wr_addr] <= prog_wr_data;
    rd_q <= mem[icache_req_addr[MEM_ADDR_WIDTH-1:0]];
  end

`ifdef VX_ICACHE_RESPONDER_BOUNDS_EN
  logic                       req_oob;
  logic                       rd_oob_q;
  logic                       err_q;
  logic [IMEM_ADDR_WIDTH-1:0] err_addr_q;

  assign req_oob = |icache_req_addr[IMEM_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  // Out-of-range marker travels alongside the RAM read
  always_ff @(posedge clk) begin
    rd_oob_q <= req_oob;
  end

  // Sticky error capture of the first out-of-range fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (req_fire && req_oob && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= icache_req_addr;
    end
  end

  assign st0_data = rd_oob_q ? IMEM_NOP : rd_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^icache_req_addr[IMEM_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign st0_data       = rd_q;
  assign err            = 1'b0;
  assign err_addr       = '0;
`endif

  // Valid shift register; reset flushes every in-flight entry
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv[0] <= req_fire;
      for (int unsigned i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
    end
  end

  // Tag shift register, qualified downstream by the valid bits
  always_ff @(posedge clk) begin
    pt[0] <= icache_req_tag;
    for (int unsigned i = 1; i < LATENCY; i++) pt[i] <= pt[i-1];
  end

  // Data delay stages after the RAM output register
  generate
    if (LATENCY == 1) begin : g_lat1
      assign tail_data = st0_data;
    end else begin : g_latn
      logic [IMEM_WORD_WIDTH-1:0] pd [LATENCY-1];
      // Delay line from RAM read to pipeline tail
      always_ff @(posedge clk) begin
        pd[0] <= st0_data;
        for (int unsigned i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
      end
      assign tail_data = pd[LATENCY-2];
    end
  endgenerate

  assign tail_valid = pv[LATENCY-1];
  assign tail_rsp   = '{data: tail_data, tag: pt[LATENCY-1]};

  // Tail bypasses the buffer only when it is empty and the consumer takes it
  assign buf_pop  = !buf_empty && icache_rsp_ready;
  assign buf_push = tail_valid && !(buf_empty && icache_rsp_ready);

  VX_icache_rsp_buf #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (tail_rsp),
    .pop       (buf_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // Output select: buffer head first, else pipeline tail, else zeros
  always_comb begin
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    icache_rsp_tag   = '0;
    if (!buf_empty) begin
      icache_rsp_valid = 1'b1;
      icache_rsp_data  = buf_head.data;
      icache_rsp_tag   = buf_head.tag;
    end else if (tail_valid) begin
      icache_rsp_valid = 1'b1;
      icache_rsp_data  = tail_rsp.data;
      icache_rsp_tag   = tail_rsp.tag;
    end
  end

  // Credit scheme must keep the buffer from ever overflowing
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(buf_push && buf_full))
        else $error("vx_icache_responder[%0d]: response buffer overflow", CORE_ID);
    end
  end

endmodule

// File: tb/tb_vx_icache_responder.sv
// Self-checking bench for vx_icache_responder (default parameters).
module tb_vx_icache_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int MAW   = 14;
  localparam int TW    = 8;
`ifdef VX_ICACHE_RESPONDER_BOUNDS_EN
  localparam bit BND = 1'b1;
`else
  localparam bit BND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_req_valid;
  logic [29:0]   icache_req_addr;
  logic [TW-1:0] icache_req_tag;
  logic          icache_req_ready;
  logic          icache_rsp_valid;
  logic [31:0]   icache_rsp_data;
  logic [TW-1:0] icache_rsp_tag;
  logic          icache_rsp_ready;
  logic          prog_wr_en;
  logic [MAW-1:0] prog_wr_addr;
  logic [31:0]   prog_wr_data;
  logic          busy;
  logic          err;
  logic [29:0]   err_addr;

  int total = 0;
  int bad   = 0;
  int cycno = 0;
  int accepted;

  typedef struct {
    logic [29:0]   addr;
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } vec_t;

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [0:(1<<MAW)-1];
  vec_t        vecs [6];

  always #5 clk = ~clk;
  always @(posedge clk) cycno <= cycno + 1;

  vx_icache_responder #(
    .CORE_ID        (0),
    .TAG_WIDTH      (TW),
    .MEM_ADDR_WIDTH (MAW),
    .LATENCY        (LAT),
    .RSP_DEPTH      (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_req_tag   (icache_req_tag),
    .icache_req_ready (icache_req_ready),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .icache_rsp_tag   (icache_rsp_tag),
    .icache_rsp_ready (icache_rsp_ready),
    .prog_wr_en       (prog_wr_en),
    .prog_wr_addr     (prog_wr_addr),
    .prog_wr_data     (prog_wr_data),
    .busy             (busy),
    .err              (err),
    .err_addr         (err_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycno);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic prog(input logic [MAW-1:0] a, input logic [31:0] d);
    prog_wr_en   = 1'b1;
    prog_wr_addr = a;
    prog_wr_data = d;
    mm[a]        = d;
    tick();
    prog_wr_en   = 1'b0;
  endtask

  task automatic fetch(input logic [29:0] a, input logic [TW-1:0] t);
    icache_req_valid = 1'b1;
    icache_req_addr  = a;
    icache_req_tag   = t;
  endtask

  // One random cycle checked against an ordered list of due responses
  task automatic rand_cycle(input bit gen);
    bit            ev, er, rr, rv, we;
    logic [5:0]    a, wa;
    logic [TW-1:0] t;
    logic [31:0]   wd;
    ev = (q.size() > 0) && (q[0].due <= cycno);
    er = (q.size() < DEPTH);
    chk("rnd_valid", icache_rsp_valid, ev);
    chk("rnd_ready", icache_req_ready, er);
    chk("rnd_busy", busy, q.size() != 0);
    if (ev) begin
      chk("rnd_data", icache_rsp_data, q[0].data);
      chk("rnd_tag", icache_rsp_tag, q[0].tag);
    end
    rr = ($urandom_range(0, 3) != 0);
    rv = gen && ($urandom_range(0, 1) == 1);
    a  = 6'($urandom);
    t  = TW'($urandom);
    we = ($urandom_range(0, 15) == 0);
    wa = 6'($urandom);
    wd = $urandom;
    icache_rsp_ready = rr;
    icache_req_valid = rv;
    icache_req_addr  = {24'd0, a};
    icache_req_tag   = t;
    prog_wr_en       = we;
    prog_wr_addr     = {8'd0, wa};
    prog_wr_data     = wd;
    if (ev && rr) void'(q.pop_front());
    if (rv && er) begin
      q.push_back('{data: mm[a], tag: t, due: cycno + LAT});
      accepted++;
    end
    if (we) mm[wa] = wd;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; icache_req_valid = 1'b0; icache_req_addr = '0; icache_req_tag = '0;
    icache_rsp_ready = 1'b0; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    @(negedge clk);
    tick(); tick();
    chk("rst_ready", icache_req_ready, 1);
    chk("rst_rsp_valid", icache_rsp_valid, 0);
    chk("rst_rsp_data", icache_rsp_data, 0);
    chk("rst_rsp_tag", icache_rsp_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    reset = 1'b0;

    prog(14'd0, 32'h11111111);
    prog(14'd1, 32'h22222222);
    prog(14'd2, 32'h33333333);
    prog(14'd3, 32'h44444444);
    prog(14'd7, 32'h77777777);
    prog(14'd100, 32'h0badc0de);
    prog(14'h3fff, 32'hcafef00d);

    // back-to-back reads, responses in cycles LAT and LAT+1
    icache_rsp_ready = 1'b1;
    fetch(30'd0, 8'd5);
    tick();
    chk("b2b_c1_valid", icache_rsp_valid, 0);
    chk("b2b_c1_busy", busy, 1);
    fetch(30'd1, 8'd6);
    tick();
    icache_req_valid = 1'b0;
    chk("b2b_c2_valid", icache_rsp_valid, 1);
    chk("b2b_c2_data", icache_rsp_data, 32'h11111111);
    chk("b2b_c2_tag", icache_rsp_tag, 5);
    tick();
    chk("b2b_c3_valid", icache_rsp_valid, 1);
    chk("b2b_c3_data", icache_rsp_data, 32'h22222222);
    chk("b2b_c3_tag", icache_rsp_tag, 6);
    tick();
    chk("b2b_c4_valid", icache_rsp_valid, 0);
    chk("b2b_c4_busy", busy, 0);

    // table of single reads
    vecs[0] = '{addr: 30'd2,     tag: 8'h10, data: 32'h33333333};
    vecs[1] = '{addr: 30'd3,     tag: 8'h11, data: 32'h44444444};
    vecs[2] = '{addr: 30'd100,   tag: 8'h12, data: 32'h0badc0de};
    vecs[3] = '{addr: 30'h3fff,  tag: 8'h13, data: 32'hcafef00d};
    vecs[4] = '{addr: 30'd7,     tag: 8'h14, data: 32'h77777777};
    vecs[5] = '{addr: 30'd1,     tag: 8'hff, data: 32'h22222222};
    for (int i = 0; i < 6; i++) begin
      fetch(vecs[i].addr, vecs[i].tag);
      tick();
      icache_req_valid = 1'b0;
      for (int k = 1; k < LAT; k++) tick();
      chk("tbl_valid", icache_rsp_valid, 1);
      chk("tbl_data", icache_rsp_data, vecs[i].data);
      chk("tbl_tag", icache_rsp_tag, vecs[i].tag);
      tick();
      chk("tbl_idle", busy, 0);
    end

    // backpressure: only DEPTH requests accepted, held stable, drained in order
    icache_rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fetch(30'(i % 4), 8'(8'h40 + i));
      chk("bp_ready", icache_req_ready, i < DEPTH);
      tick();
    end
    icache_req_valid = 1'b0;
    tick();
    chk("bp_full_ready", icache_req_ready, 0);
    chk("bp_full_busy", busy, 1);
    chk("bp_head_valid", icache_rsp_valid, 1);
    chk("bp_head_tag", icache_rsp_tag, 8'h40);
    tick();
    chk("bp_hold_tag", icache_rsp_tag, 8'h40);
    chk("bp_hold_data", icache_rsp_data, mm[0]);
    icache_rsp_ready = 1'b1;
    tick();
    chk("bp_ready_rise", icache_req_ready, 1);
    chk("bp_tag41", icache_rsp_tag, 8'h41);
    chk("bp_data41", icache_rsp_data, mm[1]);
    fetch(30'd0, 8'h50);
    tick();
    icache_req_valid = 1'b0;
    chk("bp_simul_ready", icache_req_ready, 1);
    chk("bp_tag42", icache_rsp_tag, 8'h42);
    tick();
    chk("bp_tag43", icache_rsp_tag, 8'h43);
    chk("bp_data43", icache_rsp_data, mm[3]);
    tick();
    chk("bp_tag50", icache_rsp_tag, 8'h50);
    chk("bp_data50", icache_rsp_data, mm[0]);
    tick();
    chk("bp_end_valid", icache_rsp_valid, 0);
    chk("bp_end_busy", busy, 0);
    chk("bp_end_ready", icache_req_ready, 1);

    // program write and fetch of the same address in the same cycle
    prog_wr_en = 1'b1; prog_wr_addr = 14'd7; prog_wr_data = 32'hdeadbeef;
    fetch(30'd7, 8'h21);
    tick();
    prog_wr_en = 1'b0;
    fetch(30'd7, 8'h22);
    tick();
    icache_req_valid = 1'b0;
    chk("rw_old_data", icache_rsp_data, 32'h77777777);
    chk("rw_old_tag", icache_rsp_tag, 8'h21);
    tick();
    chk("rw_new_data", icache_rsp_data, 32'hdeadbeef);
    chk("rw_new_tag", icache_rsp_tag, 8'h22);
    mm[7] = 32'hdeadbeef;
    tick();

    // out-of-range fetch
    chk("oob_err_before", err, 0);
    fetch(30'h4000, 8'h33);
    tick();
    icache_req_valid = 1'b0;
    tick();
    chk("oob_data", icache_rsp_data, BND ? 32'h00000013 : mm[0]);
    chk("oob_tag", icache_rsp_tag, 8'h33);
    chk("oob_err", err, BND);
    chk("oob_err_addr", err_addr, BND ? 30'h4000 : 30'h0);
    fetch(30'h8003, 8'h34);
    tick();
    icache_req_valid = 1'b0;
    tick();
    chk("oob2_data", icache_rsp_data, BND ? 32'h00000013 : mm[3]);
    chk("oob2_err_addr", err_addr, BND ? 30'h4000 : 30'h0);
    tick();

    // reset with three requests in flight
    icache_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch(30'(i), 8'(8'h70 + i));
      tick();
    end
    icache_req_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_valid", icache_rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", icache_req_ready, 1);
    chk("mrst_err", err, 0);
    reset = 1'b0;
    icache_rsp_ready = 1'b1;
    fetch(30'd2, 8'h60);
    tick();
    icache_req_valid = 1'b0;
    chk("mrst_c1_valid", icache_rsp_valid, 0);
    tick();
    chk("mrst_new_valid", icache_rsp_valid, 1);
    chk("mrst_new_tag", icache_rsp_tag, 8'h60);
    chk("mrst_new_data", icache_rsp_data, mm[2]);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_no_stale", icache_rsp_valid, 0);
    end

    // randomized traffic with random backpressure and program writes
    for (int a = 0; a < 64; a++) prog(14'(a), $urandom);
    q.delete();
    accepted = 0;
    for (int c = 0; c < 20000 && accepted < 1000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 80 && q.size() > 0; c++) rand_cycle(1'b0);
    prog_wr_en = 1'b0;
    icache_req_valid = 1'b0;
    chk("rnd_accepted", accepted, 1000);
    chk("rnd_drained", q.size(), 0);
    chk("rnd_final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
